// File: rtl/jump_and_branch_logic_pkg.sv
// Shared control-flow decode constants and a saturating increment helper.
package jump_and_branch_logic_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/jump_and_branch_logic_branch_compare.sv
// Branch condition evaluation: equality on rs/rt, signed zero compare on rs.
module branch_compare
  import jump_and_branch_logic_pkg::*;
(
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [5:0]  opcode_i,
  output logic        cond_o
);

  logic signed [31:0] rs_s;
  assign rs_s = rs_i;

  always_comb begin
    cond_o = 1'b0;
    case (opcode_i)
      OP_BEQ:  cond_o = (rs_i == rt_i);
      OP_BNE:  cond_o = (rs_i != rt_i);
      OP_BLEZ: cond_o = (rs_s <= 32'sd0);
      OP_BGTZ: cond_o = (rs_s >  32'sd0);
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/jump_and_branch_logic.sv
// ID-stage control-flow resolver: next-PC select plus saturating profiling counters.
module jump_and_branch_logic
  import jump_and_branch_logic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instructions,
  input  logic [31:0] Rs,
  input  logic [31:0] Rt,
  input  logic [31:0] PCplusOne,
  input  logic [31:0] SE_Imm,
  output logic [31:0] ID_PC,
  output logic        PCSource,
  output logic [31:0] branch_count,
  output logic [31:0] taken_count
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        br_cond;
  logic        is_branch;
  logic        is_jump;
  logic        taken;
  logic [31:0] target;

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q,  taken_cnt_d;

  assign opcode = instructions[31:26];
  assign funct  = instructions[5:0];

  branch_compare u_branch_compare (
    .rs_i     (Rs),
    .rt_i     (Rt),
    .opcode_i (opcode),
    .cond_o   (br_cond)
  );

  always_comb begin
    is_branch = 1'b0;
    is_jump   = 1'b0;
    target    = PCplusOne;
    case (opcode)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        is_branch = 1'b1;
        // Word-addressed PC: the immediate is already in words, no shift.
        target    = PCplusOne + SE_Imm;
      end
      OP_J, OP_JAL: begin
        is_jump = 1'b1;
        target  = {PCplusOne[31:26], instructions[25:0]};
      end
      OP_RTYPE: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          is_jump = 1'b1;
          target  = Rs;
        end
      end
      default: begin
        is_branch = 1'b0;
        is_jump   = 1'b0;
      end
    endcase
  end

  assign taken    = is_jump | (is_branch & br_cond);
  assign PCSource = taken;
  assign ID_PC    = taken ? target : PCplusOne;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (is_branch || is_jump) branch_cnt_d = sat_inc(branch_cnt_q);
    if (taken)                taken_cnt_d  = sat_inc(taken_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_count = branch_cnt_q;
  assign taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_jump_and_branch_logic.sv
// Self-checking bench: directed vector table, counter sequences and randomized model comparison.
module tb_jump_and_branch_logic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instructions, Rs, Rt, PCplusOne, SE_Imm;
  logic [31:0] ID_PC, branch_count, taken_count;
  logic        PCSource;

  int n_cmp = 0;
  int n_err = 0;

  longint unsigned m_br, m_tk;

  jump_and_branch_logic dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instructions (instructions),
    .Rs           (Rs),
    .Rt           (Rt),
    .PCplusOne    (PCplusOne),
    .SE_Imm       (SE_Imm),
    .ID_PC        (ID_PC),
    .PCSource     (PCSource),
    .branch_count (branch_count),
    .taken_count  (taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ins, rs, rt, pc1, imm;
    logic        exp_src;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: decode by opcode number and compute architectural behaviour directly.
  function automatic void model(input logic [31:0] ins, rs, rt, pc1, imm,
                                output logic src, output logic [31:0] npc,
                                output logic cf);
    int op, fn;
    logic take;
    logic [31:0] tgt;
    op   = int'(ins[31:26]);
    fn   = int'(ins[5:0]);
    take = 1'b0;
    cf   = 1'b0;
    tgt  = pc1 + imm;
    if (op >= 4 && op <= 7) begin
      cf = 1'b1;
      if (op == 4) take = (rs == rt);
      if (op == 5) take = (rs != rt);
      if (op == 6) take = ($signed(rs) <= 0);
      if (op == 7) take = ($signed(rs) > 0);
    end else if (op == 2 || op == 3) begin
      cf   = 1'b1;
      take = 1'b1;
      tgt  = (pc1 & 32'hFC00_0000) | (ins & 32'h03FF_FFFF);
    end else if (op == 0 && (fn == 8 || fn == 9)) begin
      cf   = 1'b1;
      take = 1'b1;
      tgt  = rs;
    end
    src = take;
    npc = take ? tgt : pc1;
  endfunction

  function automatic longint unsigned sat(input longint unsigned v);
    return (v + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  task automatic apply(input logic [31:0] ins, rs, rt, pc1, imm);
    instructions = ins; Rs = rs; Rt = rt; PCplusOne = pc1; SE_Imm = imm;
  endtask

  initial begin
    logic        e_src, e_cf;
    logic [31:0] e_pc, r, ins;
    int          k;

    rst_n = 1'b0;
    apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    vecs.push_back('{"nonbr",  32'h8000_0020, 32'd15, 32'd15, 32'd14, 32'hFFFF_FFFD, 1'b0, 32'd14});
    vecs.push_back('{"beq_t",  32'h1000_FFFD, 32'd15, 32'd15, 32'd14, 32'hFFFF_FFFD, 1'b1, 32'd11});
    vecs.push_back('{"bne_nt", 32'h1400_FFFD, 32'd15, 32'd15, 32'd14, 32'hFFFF_FFFD, 1'b0, 32'd14});
    vecs.push_back('{"bne_t",  32'h1400_FFFD, 32'd15, 32'd16, 32'd14, 32'hFFFF_FFFD, 1'b1, 32'd11});
    vecs.push_back('{"blez_0", 32'h1800_0005, 32'd0,  32'd0,  32'd100, 32'd5, 1'b1, 32'd105});
    vecs.push_back('{"blez_m1",32'h1800_0005, 32'hFFFF_FFFF, 32'd0, 32'd100, 32'd5, 1'b1, 32'd105});
    vecs.push_back('{"blez_1", 32'h1800_0005, 32'd1,  32'd0,  32'd100, 32'd5, 1'b0, 32'd100});
    vecs.push_back('{"bgtz_0", 32'h1C00_0005, 32'd0,  32'd0,  32'd100, 32'd5, 1'b0, 32'd100});
    vecs.push_back('{"bgtz_m1",32'h1C00_0005, 32'hFFFF_FFFF, 32'd0, 32'd100, 32'd5, 1'b0, 32'd100});
    vecs.push_back('{"bgtz_1", 32'h1C00_0005, 32'd1,  32'd0,  32'd100, 32'd5, 1'b1, 32'd105});
    vecs.push_back('{"bgtz_min",32'h1C00_0005, 32'h8000_0000, 32'd0, 32'd100, 32'd5, 1'b0, 32'd100});
    vecs.push_back('{"j",      32'h0800_0123, 32'd0,  32'd0,  32'hFC00_0010, 32'd0, 1'b1, 32'hFC00_0123});
    vecs.push_back('{"jal",    32'h0FFF_FFFF, 32'd0,  32'd0,  32'h0400_0010, 32'd0, 1'b1, 32'h07FF_FFFF});
    vecs.push_back('{"jr",     32'h0020_0008, 32'h40, 32'd0,  32'd7, 32'd0, 1'b1, 32'h40});
    vecs.push_back('{"jalr",   32'h0020_0009, 32'h1234, 32'd0, 32'd7, 32'd0, 1'b1, 32'h1234});
    vecs.push_back('{"add",    32'h0020_0020, 32'h40, 32'd0,  32'd7, 32'd0, 1'b0, 32'd7});
    vecs.push_back('{"wrap",   32'h1000_0002, 32'd3,  32'd3,  32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1});

    #2;
    chk("rst_branch_count", branch_count, 32'd0);
    chk("rst_taken_count",  taken_count,  32'd0);

    // Combinational outputs are checked while reset holds the counters.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ins, vecs[i].rs, vecs[i].rt, vecs[i].pc1, vecs[i].imm);
      #1;
      chk({vecs[i].name, "_src"}, {31'd0, PCSource}, {31'd0, vecs[i].exp_src});
      chk({vecs[i].name, "_pc"},  ID_PC, vecs[i].exp_pc);
    end
    @(posedge clk); #1;
    chk("rst_hold_branch", branch_count, 32'd0);
    chk("rst_hold_taken",  taken_count,  32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h1000_FFFD, 32'd15, 32'd15, 32'd14, 32'hFFFF_FFFD);
    for (int c = 0; c < 3; c++) @(posedge clk);
    #1;
    apply(32'h8000_0020, 32'd15, 32'd15, 32'd14, 32'hFFFF_FFFD);
    for (int c = 0; c < 2; c++) @(posedge clk);
    #1;
    chk("seq_branch_count", branch_count, 32'd3);
    chk("seq_taken_count",  taken_count,  32'd3);

    // Untaken branch: only branch_count moves.
    apply(32'h1400_FFFD, 32'd15, 32'd15, 32'd14, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    chk("nt_branch_count", branch_count, 32'd4);
    chk("nt_taken_count",  taken_count,  32'd3);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_branch", branch_count, 32'd0);
    chk("async_rst_taken",  taken_count,  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("resume_branch", branch_count, 32'd1);
    chk("resume_taken",  taken_count,  32'd0);

    m_br = 1;
    m_tk = 0;
    for (int n = 0; n < 400; n++) begin
      k   = $urandom_range(0, 10);
      ins = $urandom();
      case (k)
        0: ins[31:26] = 6'd0;
        1: ins[31:26] = 6'd2;
        2: ins[31:26] = 6'd3;
        3: ins[31:26] = 6'd4;
        4: ins[31:26] = 6'd5;
        5: ins[31:26] = 6'd6;
        6: ins[31:26] = 6'd7;
        7: begin ins[31:26] = 6'd0; ins[5:0] = 6'd8; end
        8: begin ins[31:26] = 6'd0; ins[5:0] = 6'd9; end
        default: ;
      endcase
      apply(ins, $urandom(), $urandom(), $urandom(), $urandom());
      r = $urandom_range(0, 3);
      if (r == 0) Rt = Rs;
      if (r == 1) Rs = 32'd0;
      if (r == 2) Rs = $urandom_range(0, 2) - 1;
      #1;
      model(instructions, Rs, Rt, PCplusOne, SE_Imm, e_src, e_pc, e_cf);
      chk("rand_src", {31'd0, PCSource}, {31'd0, e_src});
      chk("rand_pc",  ID_PC, e_pc);
      if (e_cf)  m_br = sat(m_br);
      if (e_src) m_tk = sat(m_tk);
      @(posedge clk); #1;
      chk("rand_branch_count", branch_count, m_br[31:0]);
      chk("rand_taken_count",  taken_count,  m_tk[31:0]);
    end

    // Saturation: preload the counter state just below the ceiling.
    force dut.branch_cnt_q = 32'hFFFF_FFFE;
    force dut.taken_cnt_q  = 32'hFFFF_FFFD;
    #1;
    release dut.branch_cnt_q;
    release dut.taken_cnt_q;
    m_br = 64'hFFFF_FFFE;
    m_tk = 64'hFFFF_FFFD;
    apply(32'h1000_FFFD, 32'd15, 32'd15, 32'd14, 32'hFFFF_FFFD);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      m_br = sat(m_br);
      m_tk = sat(m_tk);
      chk("sat_branch_count", branch_count, m_br[31:0]);
      chk("sat_taken_count",  taken_count,  m_tk[31:0]);
    end
    chk("sat_final_branch", branch_count, 32'hFFFF_FFFF);
    chk("sat_final_taken",  taken_count,  32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
